// File: rtl/valid_pkg.sv
// Shared types for the valid-table controller: access sizes, FSM states, byte-mask helper.
package valid_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } size_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam int unsigned ROW_BYTES = 4;

  // Bytes covered by an access of the given size, relative to its base address.
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    logic [3:0] m;
    case (sz)
      SZ_BYTE: m = 4'b0001;
      SZ_HALF: m = 4'b0011;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: grants are combinational, priority flips after each grant.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0_c,
  output logic gnt1_c
);

  logic prio0;

  // Requester 0 wins when it has priority or requester 1 is idle.
  assign gnt0_c = en & req0 & (prio0 | ~req1);
  assign gnt1_c = en & req1 & ~gnt0_c;

  // Priority goes to whoever was not granted most recently; requester 0 first after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio0 <= 1'b1;
    end else if (gnt0_c) begin
      prio0 <= 1'b0;
    end else if (gnt1_c) begin
      prio0 <= 1'b1;
    end
  end

endmodule

// File: rtl/valid_table_ctrl.sv
// Valid-table controller: arbitrates fill/lookup commands and sweeps the table on flush.
module valid_table_ctrl
  import valid_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned ROWS   = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill_req,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [1:0]        fill_size,
  output logic              fill_gnt,
  input  logic              lk_req,
  input  logic [ADDR_W-1:0] lk_addr,
  input  logic [1:0]        lk_size,
  output logic              lk_gnt,
  output logic              lk_rvalid,
  output logic [3:0]        lk_vmask,
  output logic              lk_hit,
  input  logic              flush_req,
  output logic              flush_busy,
  output logic              flush_done,
  output logic              size_err,
  output logic              vt_we,
  output logic              vt_clr,
  output logic [ADDR_W-1:0] vt_addr,
  output logic [1:0]        vt_size,
  input  logic [3:0]        vt_valid
);

  localparam int unsigned CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_e           state;
  state_e           state_nxt;
  logic [CNT_W-1:0] row;
  logic [CNT_W-1:0] row_nxt;
  logic             done_nxt;
  logic             arb_en;
  logic             arb_fill;
  logic             arb_lk;
  logic [3:0]       lk_mask_q;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (arb_en),
    .req0   (fill_req),
    .req1   (lk_req),
    .gnt0_c (arb_fill),
    .gnt1_c (arb_lk)
  );

  // Next state and table command; grants and strobes are held low while reset is asserted.
  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    done_nxt  = 1'b0;
    arb_en    = 1'b0;
    fill_gnt  = 1'b0;
    lk_gnt    = 1'b0;
    vt_we     = 1'b0;
    vt_clr    = 1'b0;
    vt_addr   = '0;
    vt_size   = '0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (flush_req) begin
            state_nxt = ST_FLUSH;
            row_nxt   = '0;
          end else begin
            arb_en   = 1'b1;
            fill_gnt = arb_fill;
            lk_gnt   = arb_lk;
            if (arb_fill) begin
              vt_we   = (fill_size != SZ_ILL);
              vt_addr = fill_addr;
              vt_size = fill_size;
            end else if (arb_lk) begin
              vt_addr = lk_addr;
              vt_size = lk_size;
            end
          end
        end
        ST_FLUSH: begin
          vt_clr  = 1'b1;
          vt_addr = ADDR_W'({row, 2'b00});
          vt_size = SZ_WORD;
          if (row == CNT_W'(ROWS - 1)) begin
            state_nxt = ST_IDLE;
            row_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            row_nxt = row + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          row_nxt   = '0;
        end
      endcase
    end
  end

  // State, row counter and one-cycle result/status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      row        <= '0;
      flush_done <= 1'b0;
      size_err   <= 1'b0;
      lk_rvalid  <= 1'b0;
      lk_mask_q  <= '0;
    end else begin
      state      <= state_nxt;
      row        <= row_nxt;
      flush_done <= done_nxt;
      size_err   <= (fill_gnt && (fill_size == SZ_ILL)) || (lk_gnt && (lk_size == SZ_ILL));
      lk_rvalid  <= lk_gnt;
      lk_mask_q  <= lk_gnt ? size_mask(lk_size) : 4'b0000;
    end
  end

  // Table data arrives the cycle after the lookup command, aligned with lk_rvalid.
  assign lk_vmask   = vt_valid & lk_mask_q;
  assign lk_hit     = lk_rvalid && (lk_mask_q != 4'b0000) && ((vt_valid & lk_mask_q) == lk_mask_q);
  assign flush_busy = (state == ST_FLUSH);

endmodule
